fp_mul_arbiter: RTL

//  Shares one iterative FP multiplier (run/stall/ce interface, 32-bit x,y,z) between two

---
 rtl/fp_mul_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one iterative FP multiplier between two requesters.
// Each port latches its operands at grant, runs the multiplier until it stops
// stalling, captures the product and returns it with a one-cycle ack.
// Optional feature macro: FPMUL_ZERO_BYPASS_EN. When defined, an operand with a
// zero exponent skips the multiplier and returns 0 one cycle after the grant.
module fp_mul_arbiter #(
  parameter bit FIXED_PRIO = 1'b0   // 0: round-robin, 1: port 0 wins ties
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        req0,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  output logic        ack0,
  output logic [31:0] z0,
  input  logic        req1,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic        ack1,
  output logic [31:0] z1,
  output logic        busy,
  output logic        gnt,
  output logic        mul_ce,
  output logic        mul_run,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic        mul_stall,
  input  logic [31:0] mul_z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        rr;        // last port granted; the other port wins the next tie
  logic        any_req;
  logic        win;
  logic [31:0] win_x;
  logic [31:0] win_y;
`ifdef FPMUL_ZERO_BYPASS_EN
  logic        win_zero;
`endif

  // The multiplier counter must also clear while we are held in reset.
  assign mul_ce = ce | rst;

  // Winner selection for the IDLE grant decision.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = FIXED_PRIO ? 1'b0 : ~rr;
    end else begin
      win = req1;
    end
    win_x = win ? x1 : x0;
    win_y = win ? y1 : y0;
`ifdef FPMUL_ZERO_BYPASS_EN
    win_zero = (win_x[30:23] == 8'd0) || (win_y[30:23] == 8'd0);
`endif
  end

  // Control FSM with registered outputs; everything advances only on ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= 1'b1;
      gnt     <= 1'b0;
      busy    <= 1'b0;
      mul_run <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      z0      <= 32'd0;
      z1      <= 32'd0;
      mul_x   <= 32'd0;
      mul_y   <= 32'd0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            mul_x <= win_x;
            mul_y <= win_y;
            gnt   <= win;
            rr    <= win;
            busy  <= 1'b1;
`ifdef FPMUL_ZERO_BYPASS_EN
            if (win_zero) begin
              if (win) begin
                z1   <= 32'd0;
                ack1 <= 1'b1;
              end else begin
                z0   <= 32'd0;
                ack0 <= 1'b1;
              end
              state <= DONE;
            end else begin
              mul_run <= 1'b1;
              state   <= RUN;
            end
`else
            mul_run <= 1'b1;
            state   <= RUN;
`endif
          end
        end
        RUN: begin
          if (!mul_stall) begin
            if (gnt) begin
              z1   <= mul_z;
              ack1 <= 1'b1;
            end else begin
              z0   <= mul_z;
              ack0 <= 1'b1;
            end
            // Dropping run for the DONE cycle clears the multiplier counter.
            mul_run <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mul_run <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
